// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: ROM port, redirect/halt controls and the
// decoded-instruction output handshake.
interface fetch_unit_if #(
    parameter int ADDR_W = 10
) ();
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              halt;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [31:0]       out_pc;
    logic [5:0]        out_op;
    logic [5:0]        out_func;
    logic              halted;

    // fetch unit side
    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect,
        input  redirect_pc,
        input  halt,
        output out_valid,
        input  out_ready,
        output out_inst,
        output out_pc,
        output out_op,
        output out_func,
        output halted
    );

    // core / ROM side
    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect,
        output redirect_pc,
        output halt,
        input  out_valid,
        output out_ready,
        input  out_inst,
        input  out_pc,
        input  out_op,
        input  out_func,
        input  halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word reads to a 1-cycle synchronous
// ROM, buffers returns in a 2-entry queue and presents them with their PC
// over valid/ready. Redirects flush the queue; halt stops fetch until reset.
module fetch_unit #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic [31:0] q_inst [2];
    logic [31:0] q_pc   [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;

    logic        run, pop, issue;
    logic [2:0]  occ;
    logic        unused_rpc_lo;

    assign run = (state_q == RUN);
    assign pop = bus.out_valid & bus.out_ready;
    // slots that will be occupied after this edge if nothing new is issued
    assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue = run & ~bus.halt & ~bus.redirect & (occ < 3'd2);

    assign bus.imem_addr = fetch_pc[ADDR_W+1:2];
    assign bus.out_valid = run & (count != 2'd0);
    assign bus.out_inst  = bus.out_valid ? q_inst[rd_ptr] : 32'h0;
    assign bus.out_pc    = bus.out_valid ? q_pc[rd_ptr] : fetch_pc;
    assign bus.out_op    = bus.out_inst[31:26];
    assign bus.out_func  = bus.out_inst[5:0];
    assign bus.halted    = (state_q == HALTED);

    // target is word aligned; the low bits are dropped
    assign unused_rpc_lo = ^bus.redirect_pc[1:0];

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    // next state: halt is sticky until reset
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && bus.halt) state_d = HALTED;
    end

    // fetch PC, in-flight tracking and queue control
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else if (run) begin
            if (bus.halt) begin
                inflight <= 1'b0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
                count    <= 2'd0;
            end else if (bus.redirect) begin
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                inflight <= 1'b0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
                count    <= 2'd0;
            end else begin
                if (issue) begin
                    fetch_pc    <= fetch_pc + 32'd4;
                    inflight_pc <= fetch_pc;
                end
                inflight <= issue;
                if (inflight) wr_ptr <= ~wr_ptr;
                if (pop)      rd_ptr <= ~rd_ptr;
                count <= count + {1'b0, inflight} - {1'b0, pop};
            end
        end
    end

    // queue storage: capture the ROM return for last cycle's issue
    always_ff @(posedge clk) begin
        if (run && !bus.halt && !bus.redirect && inflight) begin
            q_inst[wr_ptr] <= bus.imem_data;
            q_pc[wr_ptr]   <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 16-word ROM (ADDR_W=4) whose word i
// holds 32'h2000_0000 | i.
module tb_fetch_unit;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    fetch_unit_if #(.ADDR_W(4)) bus ();

    fetch_unit #(.ADDR_W(4), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous ROM, one cycle of read latency
    always @(posedge clk) bus.imem_data <= 32'h2000_0000 | {28'd0, bus.imem_addr};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_pc"}, bus.out_pc, pc);
        chk({tag, "_inst"}, bus.out_inst, inst);
        chk({tag, "_op"}, {26'd0, bus.out_op}, {26'd0, inst[31:26]});
        chk({tag, "_func"}, {26'd0, bus.out_func}, {26'd0, inst[5:0]});
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
        chk({tag, "_inst"}, bus.out_inst, 32'd0);
        chk({tag, "_op"}, {26'd0, bus.out_op}, 32'd0);
        chk({tag, "_func"}, {26'd0, bus.out_func}, 32'd0);
        chk({tag, "_pc"}, bus.out_pc, 32'd0);
        chk({tag, "_halted"}, {31'd0, bus.halted}, 32'd0);
        chk({tag, "_addr"}, {28'd0, bus.imem_addr}, 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.halt        = 1'b0;

        // reset values, before any clock edge
        #1;
        chk_reset("rst0");

        // start-up: issue at E1, valid after E2, then one per cycle
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("start_e1_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        chk_head("s0", 32'h0, 32'h2000_0000);
        step();
        chk_head("s4", 32'h4, 32'h2000_0001);
        step();
        chk_head("s8", 32'h8, 32'h2000_0002);

        // backpressure for 3 cycles with pc 0x8 at the head
        bus.out_ready = 1'b0;
        repeat (3) begin
            step();
            chk_head("bp", 32'h8, 32'h2000_0002);
        end
        bus.out_ready = 1'b1;
        step();
        chk_head("bpC", 32'hC, 32'h2000_0003);
        step();
        chk_head("bp10", 32'h10, 32'h2000_0004);
        step();
        chk_head("bp14", 32'h14, 32'h2000_0005);

        // asynchronous reset pulse between edges while valid
        #1 rst = 1'b1;
        #1 chk_reset("arst");
        #1 rst = 1'b0;
        step();
        chk("arst_e1_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        chk_head("ar0", 32'h0, 32'h2000_0000);
        step();
        step();
        step();
        chk_head("arC", 32'hC, 32'h2000_0003);

        // redirect to 0x43 (-> 0x40) while 0xC queued and 0x10 in flight
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h43;
        step();
        bus.redirect = 1'b0;
        chk("rd_e0_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rd_e0_addr", {28'd0, bus.imem_addr}, 32'd0);
        step();
        chk("rd_e1_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        chk_head("rd40", 32'h40, 32'h2000_0000);
        step();
        chk_head("rd44", 32'h44, 32'h2000_0001);

        // natural wrap of the ROM address past pc 0x3C
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h38;
        step();
        bus.redirect = 1'b0;
        chk("wr_addr14", {28'd0, bus.imem_addr}, 32'd14);
        step();
        chk("wr_addr15", {28'd0, bus.imem_addr}, 32'd15);
        step();
        chk("wr_addr0", {28'd0, bus.imem_addr}, 32'd0);
        chk_head("wr38", 32'h38, 32'h2000_000E);
        step();
        chk_head("wr3C", 32'h3C, 32'h2000_000F);
        step();
        chk_head("wr40", 32'h40, 32'h2000_0000);
        chk("wr_addr2", {28'd0, bus.imem_addr}, 32'd2);

        // halt and redirect together: halt wins, fetch PC frozen at 0x48
        bus.halt        = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        step();
        bus.halt     = 1'b0;
        bus.redirect = 1'b0;
        chk("h_halted", {31'd0, bus.halted}, 32'd1);
        chk("h_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("h_inst", bus.out_inst, 32'd0);
        chk("h_addr", {28'd0, bus.imem_addr}, 32'd2);
        for (int i = 0; i < 20; i++) begin
            bus.redirect    = i[0];
            bus.redirect_pc = 32'h80;
            bus.out_ready   = ~i[1];
            step();
            chk("hz_halted", {31'd0, bus.halted}, 32'd1);
            chk("hz_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("hz_addr", {28'd0, bus.imem_addr}, 32'd2);
        end
        bus.redirect  = 1'b0;
        bus.out_ready = 1'b1;

        // reset leaves HALTED and restarts at RESET_PC
        #1 rst = 1'b1;
        #1 chk_reset("hrst");
        #1 rst = 1'b0;
        step();
        chk("hr_e1_valid", {31'd0, bus.out_valid}, 32'd0);
        step();
        chk_head("hr0", 32'h0, 32'h2000_0000);
        step();
        chk_head("hr4", 32'h4, 32'h2000_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
